// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package muldiv_pkg;

    localparam int unsigned MULDIV_WIDTH = 32;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2
    } muldiv_state_e;

    function automatic logic is_div_op(input muldiv_op_e op);
        return (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic is_signed_op(input muldiv_op_e op);
        return (op == MULT) || (op == DIV);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Execute-stage <-> multiply/divide sequencer handshake and HI/LO result bus.
interface muldiv_ctrl_if #(
    parameter int unsigned WIDTH = muldiv_pkg::MULDIV_WIDTH
);
    import muldiv_pkg::*;

    logic             start_i;
    muldiv_op_e       op_i;
    logic [WIDTH-1:0] src_a_i;
    logic [WIDTH-1:0] src_b_i;
    logic             hilo_read_i;
    logic             flush_i;
    logic             busy_o;
    logic             stall_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, op_i, src_a_i, src_b_i, hilo_read_i, flush_i,
        input  busy_o, stall_o, done_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, src_a_i, src_b_i, hilo_read_i, flush_i,
        output busy_o, stall_o, done_o, hi_o, lo_o
    );

endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide sequencer owning the HI/LO register pair.
// Shift-add multiply and restoring divide on operand magnitudes, one bit per RUN cycle,
// followed by a single FIXUP cycle for sign correction and the HI/LO write.
// Optional feature: define MULDIV_EARLY_OUT_EN to let multiplies leave RUN as soon as the
// remaining multiplier bits are all zero.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_WIDTH
) (
    input logic         clk_i,
    input logic         rst_i,
    muldiv_ctrl_if.slave bus
);

    localparam int unsigned CntW = $clog2(WIDTH);

    muldiv_state_e      state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    muldiv_op_e         op_q, op_d;
    logic               neg_res_q, neg_res_d;   // negate product / quotient
    logic               neg_rem_q, neg_rem_d;   // negate remainder (dividend sign)
    logic               dbz_q, dbz_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;           // mul: product; div: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] opb_q, opb_d;           // mul: shifted multiplicand; div: divisor in low half
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               sgn_a, sgn_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] acc_mul;
    logic [WIDTH:0]     trial, diff;
    logic               qbit;
    logic [2*WIDTH-1:0] acc_div;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;
    logic               mul_last;

    // Operand magnitudes and one iteration of each datapath.
    always_comb begin
        sgn_a = is_signed_op(bus.op_i) & bus.src_a_i[WIDTH-1];
        sgn_b = is_signed_op(bus.op_i) & bus.src_b_i[WIDTH-1];
        mag_a = sgn_a ? -bus.src_a_i : bus.src_a_i;
        mag_b = sgn_b ? -bus.src_b_i : bus.src_b_i;

        acc_mul = acc_q + (mplier_q[0] ? opb_q : '0);

        trial   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff    = trial - {1'b0, opb_q[WIDTH-1:0]};
        qbit    = ~diff[WIDTH];
        acc_div = {(qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0]), acc_q[WIDTH-2:0], qbit};

        prod_fix = neg_res_q ? -acc_q : acc_q;
        quot_fix = dbz_q ? '1 : (neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
        rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

`ifdef MULDIV_EARLY_OUT_EN
        mul_last = (mplier_q >> 1) == '0;
`else
        mul_last = 1'b0;
`endif
    end

    // Sequencer next-state and HI/LO update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        mplier_d  = mplier_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start_i && !bus.flush_i) begin
                    case (bus.op_i)
                        MULT, MULTU, DIV, DIVU: begin
                            state_d   = RUN;
                            cnt_d     = CntW'(WIDTH - 1);
                            op_d      = bus.op_i;
                            neg_res_d = sgn_a ^ sgn_b;
                            neg_rem_d = sgn_a;
                            dbz_d     = is_div_op(bus.op_i) && (bus.src_b_i == '0);
                            mplier_d  = mag_b;
                            if (is_div_op(bus.op_i)) begin
                                acc_d = {{WIDTH{1'b0}}, mag_a};
                                opb_d = {{WIDTH{1'b0}}, mag_b};
                            end else begin
                                acc_d = '0;
                                opb_d = {{WIDTH{1'b0}}, mag_a};
                            end
                        end
                        MTHI:    hi_d = bus.src_a_i;
                        MTLO:    lo_d = bus.src_a_i;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (bus.flush_i) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (is_div_op(op_q)) begin
                        acc_d = acc_div;
                    end else begin
                        acc_d    = acc_mul;
                        opb_d    = opb_q << 1;
                        mplier_d = mplier_q >> 1;
                    end
                    if (cnt_q == '0 || (!is_div_op(op_q) && mul_last)) begin
                        state_d = FIXUP;
                    end
                end
            end
            FIXUP: begin
                state_d = IDLE;
                if (!bus.flush_i) begin
                    done_d = 1'b1;
                    if (is_div_op(op_q)) begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any in-flight operation.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= MULT;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            acc_q     <= '0;
            opb_q     <= '0;
            mplier_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            mplier_q  <= mplier_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    // Outputs; stall freezes execute while an op or HI/LO read collides with a busy unit.
    always_comb begin
        bus.busy_o  = (state_q != IDLE);
        bus.stall_o = bus.busy_o & (bus.start_i | bus.hilo_read_i);
        bus.done_o  = done_q;
        bus.hi_o    = hi_q;
        bus.lo_o    = lo_q;
    end

endmodule
